// File: rtl/vga_word_prefetch.sv
// vga_word_prefetch: double-buffered SRAM word fetcher serving VGA pixels from cur/next word registers
module vga_word_prefetch #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [1:0]        vga_state,
  input  logic              vga_data_en,
  input  logic [ADDR_W-1:0] vga_word_addr,
  input  logic [4:0]        vga_bit_idx,
  output logic              pixel_data,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_byte_sel,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_busy,
  output logic              underrun,
  output logic [CNT_W-1:0]  underrun_cnt
);
  typedef enum logic [1:0] {IDLE, REQ_DEM, REQ_PRE} state_t;
  state_t state, state_nx;
  logic [31:0] cur_word, next_word;
  logic [ADDR_W-1:0] cur_tag, next_tag, addr_nx;
  logic cur_v, next_v, flush_pend;
  logic hit_c, hit_n, miss, promote, accept, discard, flush;
  assign hit_c = cur_v && cur_tag == vga_word_addr;
  assign hit_n = next_v && next_tag == vga_word_addr;
  assign miss = vga_data_en && !hit_c && !hit_n;
  assign promote = vga_data_en && hit_n && !hit_c;
  assign flush = vga_state == 2'b00;
  assign accept = state != IDLE && !sram_busy;
  assign discard = flush_pend || flush;
  assign pixel_data = vga_data_en && (hit_c ? cur_word[vga_bit_idx] : (hit_n && next_word[vga_bit_idx]));
  assign sram_req = state != IDLE;
  assign sram_byte_sel = sram_req ? 4'hF : 4'h0;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    addr_nx = sram_addr;
    if (state == IDLE) begin
      if (flush) state_nx = IDLE;
      else if (miss) begin
        state_nx = REQ_DEM;
        addr_nx = vga_word_addr;
      end else if (vga_state == 2'b01 && !cur_v) begin
        state_nx = REQ_DEM;
        addr_nx = BASE_ADDR;
      end else if (vga_state == 2'b10 && hit_c && !next_v) begin
        state_nx = REQ_PRE;
        addr_nx = vga_word_addr + ADDR_W'(1);
      end
    end else if (!sram_busy) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      sram_addr <= '0;
      cur_word <= '0;
      next_word <= '0;
      cur_tag <= '0;
      next_tag <= '0;
      cur_v <= 1'b0;
      next_v <= 1'b0;
      flush_pend <= 1'b0;
      underrun <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      sram_addr <= addr_nx;
      if (miss) underrun <= 1'b1;
      if (miss && !(&underrun_cnt)) underrun_cnt <= underrun_cnt + CNT_W'(1);
      if (promote) begin
        cur_word <= next_word;
        cur_tag <= next_tag;
        cur_v <= 1'b1;
        next_v <= 1'b0;
      end
      if (state != IDLE && flush) flush_pend <= 1'b1;
      if (accept) begin
        flush_pend <= 1'b0;
        if (discard) begin
          cur_v <= 1'b0;
          next_v <= 1'b0;
        end else if (state == REQ_DEM) begin
          cur_word <= sram_rdata;
          cur_tag <= sram_addr;
          cur_v <= 1'b1;
        end else begin
          next_word <= sram_rdata;
          next_tag <= sram_addr;
          next_v <= 1'b1;
        end
      end
      if (state == IDLE && flush) begin
        cur_v <= 1'b0;
        next_v <= 1'b0;
      end
    end
endmodule

// File: tb/tb_vga_word_prefetch.sv
// tb_vga_word_prefetch: directed self-checking bench for vga_word_prefetch
module tb_vga_word_prefetch;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic [1:0] vga_state = 2'b00;
  logic vga_data_en = 1'b0;
  logic [31:0] vga_word_addr = '0;
  logic [4:0] vga_bit_idx = '0;
  logic pixel_data, sram_req, sram_busy, underrun;
  logic [31:0] sram_addr, sram_rdata;
  logic [3:0] sram_byte_sel;
  logic [15:0] underrun_cnt;
  int checks = 0;
  int errors = 0;
  vga_word_prefetch dut (
    .clk(clk), .nrst(nrst), .vga_state(vga_state), .vga_data_en(vga_data_en),
    .vga_word_addr(vga_word_addr), .vga_bit_idx(vga_bit_idx), .pixel_data(pixel_data),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_byte_sel(sram_byte_sel),
    .sram_rdata(sram_rdata), .sram_busy(sram_busy), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );
  always #5 clk = ~clk;
  assign sram_rdata = sram_addr == 32'd0 ? 32'h8000_0001 :
                      sram_addr == 32'd1 ? 32'h4000_0000 :
                      sram_addr == 32'd2 ? 32'h0000_0F00 :
                      sram_addr == 32'd4 ? 32'hA5A5_A5A5 : 32'hDEAD_BEEF;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    sram_busy = 1'b0;
    #12;
    check("rst_req", 32'(sram_req), 32'd0);
    check("rst_addr", sram_addr, 32'd0);
    check("rst_bsel", 32'(sram_byte_sel), 32'd0);
    check("rst_pix", 32'(pixel_data), 32'd0);
    check("rst_und", 32'(underrun), 32'd0);
    check("rst_cnt", 32'(underrun_cnt), 32'd0);
    nrst = 1'b1;
    tick();
    check("idle_req", 32'(sram_req), 32'd0);
    vga_state = 2'b01;
    tick();
    check("t1_req", 32'(sram_req), 32'd1);
    check("t1_addr", sram_addr, 32'd0);
    check("t1_bsel", 32'(sram_byte_sel), 32'hF);
    tick();
    check("t1_done_req", 32'(sram_req), 32'd0);
    check("t1_und", 32'(underrun), 32'd0);
    vga_state = 2'b10;
    vga_data_en = 1'b1;
    vga_word_addr = 32'd0;
    vga_bit_idx = 5'd31;
    sram_busy = 1'b1;
    #1;
    check("t2_pix31", 32'(pixel_data), 32'd1);
    tick();
    check("t2_pre_req", 32'(sram_req), 32'd1);
    check("t2_pre_addr", sram_addr, 32'd1);
    vga_bit_idx = 5'd0;
    #1;
    check("t2_pix0", 32'(pixel_data), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_stall_req", 32'(sram_req), 32'd1);
      check("t3_stall_addr", sram_addr, 32'd1);
    end
    sram_busy = 1'b0;
    #1;
    check("t3_accept_req", 32'(sram_req), 32'd1);
    tick();
    check("t3_cap_req", 32'(sram_req), 32'd0);
    check("t3_pix", 32'(pixel_data), 32'd1);
    tick();
    check("t3_idle_req", 32'(sram_req), 32'd0);
    vga_word_addr = 32'd1;
    vga_bit_idx = 5'd30;
    #1;
    check("t4_pix_next", 32'(pixel_data), 32'd1);
    check("t4_und", 32'(underrun), 32'd0);
    tick();
    check("t4_promo_req", 32'(sram_req), 32'd0);
    check("t4_pix_cur", 32'(pixel_data), 32'd1);
    tick();
    check("t4_pre_req", 32'(sram_req), 32'd1);
    check("t4_pre_addr", sram_addr, 32'd2);
    tick();
    check("t4_cap_req", 32'(sram_req), 32'd0);
    vga_word_addr = 32'd4;
    vga_bit_idx = 5'd0;
    sram_busy = 1'b1;
    #1;
    check("t5_pix_miss", 32'(pixel_data), 32'd0);
    check("t5_und_pre", 32'(underrun), 32'd0);
    tick();
    check("t5_req", 32'(sram_req), 32'd1);
    check("t5_addr", sram_addr, 32'd4);
    check("t5_und", 32'(underrun), 32'd1);
    check("t5_cnt1", 32'(underrun_cnt), 32'd1);
    tick();
    tick();
    check("t5_cnt3", 32'(underrun_cnt), 32'd3);
    check("t5_req_hold", 32'(sram_req), 32'd1);
    sram_busy = 1'b0;
    tick();
    check("t5_cnt4", 32'(underrun_cnt), 32'd4);
    check("t5_done_req", 32'(sram_req), 32'd0);
    check("t5_pix_hit", 32'(pixel_data), 32'd1);
    vga_word_addr = 32'd2;
    vga_bit_idx = 5'd8;
    sram_busy = 1'b1;
    #1;
    check("t6_pix_next", 32'(pixel_data), 32'd1);
    tick();
    check("t6_promo_req", 32'(sram_req), 32'd0);
    tick();
    check("t6_pre_req", 32'(sram_req), 32'd1);
    check("t6_pre_addr", sram_addr, 32'd3);
    vga_state = 2'b00;
    vga_data_en = 1'b0;
    tick();
    check("t6_hold_req", 32'(sram_req), 32'd1);
    check("t6_hold_addr", sram_addr, 32'd3);
    sram_busy = 1'b0;
    tick();
    check("t6_drop_req", 32'(sram_req), 32'd0);
    tick();
    tick();
    check("t6_stay_idle", 32'(sram_req), 32'd0);
    check("t6_cnt", 32'(underrun_cnt), 32'd4);
    vga_state = 2'b01;
    tick();
    check("t6_prime_req", 32'(sram_req), 32'd1);
    check("t6_prime_addr", sram_addr, 32'd0);
    tick();
    check("t6_prime_done", 32'(sram_req), 32'd0);
    vga_state = 2'b10;
    vga_data_en = 1'b1;
    vga_word_addr = 32'd0;
    vga_bit_idx = 5'd31;
    sram_busy = 1'b1;
    #1;
    check("t6_pix", 32'(pixel_data), 32'd1);
    tick();
    check("t6_pre2_req", 32'(sram_req), 32'd1);
    check("t6_pre2_addr", sram_addr, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check("ar_req", 32'(sram_req), 32'd0);
    check("ar_addr", sram_addr, 32'd0);
    check("ar_bsel", 32'(sram_byte_sel), 32'd0);
    check("ar_pix", 32'(pixel_data), 32'd0);
    check("ar_und", 32'(underrun), 32'd0);
    check("ar_cnt", 32'(underrun_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
